// File: rtl/reservation_station.sv
// Single reservation-station entry with its execute pipe for one arithmetic FU.
// Captures operands from the register file or by snooping CDB_data, executes, then broadcasts into its ROB lane.
module reservation_station #(
    parameter int WORD_SIZE = 32,
    parameter int RB_SIZE   = 16,
    parameter int RB_INDEX  = 4,
    parameter int REG_INDEX = 5,
    parameter int FU_INDEX  = 4,
    parameter logic [FU_INDEX-1:0] FU_ID = '0,
    parameter logic [RB_INDEX-1:0] READY = '1,
    parameter int LATENCY   = 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [FU_INDEX-1:0]          CDB_inst_fu,
    input  logic [WORD_SIZE-1:0]         CDB_inst_inst,
    input  logic [RB_INDEX-1:0]          CDB_inst_RBindex,
    output logic                         busy,
    output logic [REG_INDEX-1:0]         numj,
    output logic [REG_INDEX-1:0]         numk,
    input  logic [WORD_SIZE-1:0]         vj,
    input  logic [WORD_SIZE-1:0]         vk,
    input  logic [RB_INDEX-1:0]          qj,
    input  logic [RB_INDEX-1:0]          qk,
    input  logic [RB_SIZE*WORD_SIZE-1:0] CDB_data_data,
    input  logic [RB_SIZE-1:0]           CDB_data_valid,
    output logic [RB_SIZE*WORD_SIZE-1:0] out_data,
    output logic [RB_SIZE-1:0]           out_valid
);

    localparam logic [5:0] OP_ADD  = 6'h01;
    localparam logic [5:0] OP_ADDI = 6'h02;
    localparam logic [5:0] OP_SUB  = 6'h03;
    localparam logic [5:0] OP_SUBI = 6'h04;
    localparam logic [5:0] OP_MUL  = 6'h05;
    localparam logic [5:0] OP_MULI = 6'h06;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_EXEC, S_BCAST} state_t;

    state_t                 state, state_nxt;
    logic [5:0]             op_r;
    logic [RB_INDEX-1:0]    tag_r, qj_r, qk_r;
    logic [WORD_SIZE-1:0]   vj_r, vk_r, result_r, alu;
    logic [3:0]             cnt_r;
    logic [WORD_SIZE-1:0]   lane [RB_SIZE];

    logic [5:0]             in_op;
    logic                   in_imm;
    logic [WORD_SIZE-1:0]   in_imm_val;
    logic                   accept, j_in_rdy, k_in_rdy, j_w_rdy, k_w_rdy, exec_done;
    logic                   unused_rd;

    for (genvar g = 0; g < RB_SIZE; g++) begin : g_lane
        assign lane[g] = CDB_data_data[g*WORD_SIZE +: WORD_SIZE];
    end

    assign in_op      = CDB_inst_inst[31:26];
    assign numj       = CDB_inst_inst[20:16];
    assign numk       = CDB_inst_inst[15:11];
    assign unused_rd  = ^CDB_inst_inst[25:21];
    assign in_imm     = (in_op == OP_ADDI) || (in_op == OP_SUBI) || (in_op == OP_MULI);
    assign in_imm_val = {{(WORD_SIZE-16){CDB_inst_inst[15]}}, CDB_inst_inst[15:0]};

    assign accept    = (state == S_IDLE) && (CDB_inst_fu == FU_ID);
    // Ready at accept includes a same-edge bypass from the CDB lane.
    assign j_in_rdy  = (qj == READY) || CDB_data_valid[qj];
    assign k_in_rdy  = in_imm || (qk == READY) || CDB_data_valid[qk];
    assign j_w_rdy   = (qj_r == READY) || CDB_data_valid[qj_r];
    assign k_w_rdy   = (qk_r == READY) || CDB_data_valid[qk_r];
    assign exec_done = (cnt_r == 4'(LATENCY - 1));

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept) state_nxt = (j_in_rdy && k_in_rdy) ? S_EXEC : S_WAIT;
            S_WAIT:  if (j_w_rdy && k_w_rdy) state_nxt = S_EXEC;
            S_EXEC:  if (exec_done) state_nxt = S_BCAST;
            S_BCAST: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        alu = vj_r + vk_r;
        case (op_r)
            OP_SUB, OP_SUBI: alu = vj_r - vk_r;
            OP_MUL, OP_MULI: alu = vj_r * vk_r;
            default:         alu = vj_r + vk_r;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op_r     <= '0;
            tag_r    <= '0;
            qj_r     <= READY;
            qk_r     <= READY;
            vj_r     <= '0;
            vk_r     <= '0;
            result_r <= '0;
            cnt_r    <= '0;
        end else begin
            case (state)
                S_IDLE: if (accept) begin
                    op_r  <= in_op;
                    tag_r <= CDB_inst_RBindex;
                    cnt_r <= '0;
                    if (qj == READY) begin
                        vj_r <= vj;
                        qj_r <= READY;
                    end else if (CDB_data_valid[qj]) begin
                        vj_r <= lane[qj];
                        qj_r <= READY;
                    end else begin
                        qj_r <= qj;
                    end
                    if (in_imm) begin
                        vk_r <= in_imm_val;
                        qk_r <= READY;
                    end else if (qk == READY) begin
                        vk_r <= vk;
                        qk_r <= READY;
                    end else if (CDB_data_valid[qk]) begin
                        vk_r <= lane[qk];
                        qk_r <= READY;
                    end else begin
                        qk_r <= qk;
                    end
                end
                S_WAIT: begin
                    if (qj_r != READY && CDB_data_valid[qj_r]) begin
                        vj_r <= lane[qj_r];
                        qj_r <= READY;
                    end
                    if (qk_r != READY && CDB_data_valid[qk_r]) begin
                        vk_r <= lane[qk_r];
                        qk_r <= READY;
                    end
                end
                S_EXEC: begin
                    cnt_r <= cnt_r + 4'd1;
                    if (exec_done) result_r <= alu;
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != S_IDLE);

    always_comb begin
        out_valid = '0;
        out_data  = '0;
        if (state == S_BCAST) begin
            out_valid[tag_r] = 1'b1;
            out_data[tag_r*WORD_SIZE +: WORD_SIZE] = result_r;
        end
    end

endmodule
